mul_seq: RTL

- Sequential signed 32x32 to 64-bit multiplier for the MIPS execute stage. It serves MULT (and MULTU when the optional feature is compiled in).
- It is the companion to the iterative divider and uses the same start/busy handshake, so the HI/LO control logic drives both units identically.
- Shift-add algorithm, one multiplier bit per clock, WIDTH iterations.
- The result is held in dedicated hi/lo registers until the next operation completes.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_step.sv | 36 +++
 rtl/mul_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the sequential multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned MUL_CNT_W = $clog2(MUL_WIDTH);

  // {acc, mreg} datapath word at the default width: WIDTH+1 accumulator bits over WIDTH multiplier bits
  typedef logic [2*MUL_WIDTH:0] mul_word_t;

  // Controller state; busy is the RUN flag itself
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One shift-add multiplier iteration: conditional add (or subtract on the
// last signed step) of the multiplicand into acc, then shift {acc, mreg} right.
module mul_step
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mreg,
  input  logic [WIDTH-1:0] mcand,
  input  logic             last,
  input  logic             sgn,
  output logic [2*WIDTH:0] next_c
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic           msb;

  // Add/subtract the extended multiplicand and shift in the sign (or carry)
  always_comb begin
    addend = '0;
    if (mreg[0]) begin
      addend = {sgn & mcand[WIDTH-1], mcand};
    end
    if (last && sgn) begin
      sum = acc - addend;
    end else begin
      sum = acc + addend;
    end
    // unsigned: the carry lands in acc bit WIDTH-1 and the guard bit clears
    msb    = sgn ? sum[WIDTH] : 1'b0;
    next_c = {msb, sum, mreg[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32->64 shift-add multiplier with start/busy/done handshake.
// Optional MULTU support is compiled in with `define MUL_SEQ_UNSIGNED_EN.
module mul_seq
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
`ifdef MUL_SEQ_UNSIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_t       state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mreg_q, mreg_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sgn_q, sgn_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_in;
  logic             last;
  logic [2*WIDTH:0] step_c;

`ifdef MUL_SEQ_UNSIGNED_EN
  assign sgn_in = is_signed;
`else
  assign sgn_in = 1'b1;
`endif

  assign last = (count_q == CNT_W'(WIDTH - 1));

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc_q),
    .mreg   (mreg_q),
    .mcand  (mcand_q),
    .last   (last),
    .sgn    (sgn_q),
    .next_c (step_c)
  );

  // Next-state: start reloads from any state, RUN iterates and completes
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mreg_d  = mreg_q;
    mcand_d = mcand_q;
    count_d = count_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (start) begin
      state_d = ST_RUN;
      acc_d   = '0;
      mreg_d  = b;
      mcand_d = a;
      count_d = '0;
      sgn_d   = sgn_in;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_d   = step_c[2*WIDTH:WIDTH];
          mreg_d  = step_c[WIDTH-1:0];
          count_d = count_q + CNT_W'(1);
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            hi_d    = step_c[2*WIDTH-1:WIDTH];
            lo_d    = step_c[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  // State, datapath and result registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mreg_q  <= '0;
      mcand_q <= '0;
      count_q <= '0;
      sgn_q   <= 1'b1;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mreg_q  <= mreg_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
